// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle WIDTH-bit unsigned add/sub/mul/div unit.
// A start pulse in IDLE latches the operands. Add, sub and divide-by-zero
// finish in one cycle. Multiply (shift-add, LSB first) and divide
// (restoring, MSB first) take WIDTH iterations in CALC. Every result is
// followed by a one-cycle DONE state with o_done high.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [1:0]           i_selOperator,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_divByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic [CW-1:0]      r_count;

  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Divide datapath: remainder, left-shifting dividend, divisor, quotient
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quo;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH:0]     w_shifted;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;

  // Add/sub use one extra bit so that the carry or borrow lands in bit WIDTH.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Each iteration adds one partial product when the current multiplier LSB is set.
  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The partial remainder is WIDTH+1 bits wide while it is compared. After a
  // restoring subtract it is below the divisor again, so WIDTH bits can hold it.
  assign w_shifted = {r_rem, r_dividend[WIDTH-1]};
  assign w_qBit    = (w_shifted >= {1'b0, r_divisor});
  assign w_remNext = w_qBit ? WIDTH'(w_shifted - {1'b0, r_divisor})
                            : w_shifted[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_qBit};

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

  // Control FSM and datapath registers. The result and flag are written only
  // on the transition into DONE.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_count     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quo       <= '0;
      o_result    <= '0;
      o_divByZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op <= i_selOperator;
            case (i_selOperator)
              OP_ADD: begin
                o_result    <= {{(WIDTH-1){1'b0}}, w_sum};
                o_divByZero <= 1'b0;
                r_state     <= S_DONE;
              end
              OP_SUB: begin
                o_result    <= {{(WIDTH-1){1'b0}}, w_diff};
                o_divByZero <= 1'b0;
                r_state     <= S_DONE;
              end
              OP_MUL: begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_count  <= CW'(WIDTH - 1);
                r_state  <= S_CALC;
              end
              default: begin
                if (i_b == '0) begin
                  o_result    <= '0;
                  o_divByZero <= 1'b1;
                  r_state     <= S_DONE;
                end else begin
                  r_rem      <= '0;
                  r_quo      <= '0;
                  r_dividend <= i_a;
                  r_divisor  <= i_b;
                  r_count    <= CW'(WIDTH - 1);
                  r_state    <= S_CALC;
                end
              end
            endcase
          end
        end
        S_CALC: begin
          if (r_op == OP_MUL) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_rem      <= w_remNext;
            r_quo      <= w_quoNext;
            r_dividend <= r_dividend << 1;
          end
          if (r_count == '0) begin
            o_divByZero <= 1'b0;
            o_result    <= (r_op == OP_MUL) ? w_accNext : {w_remNext, w_quoNext};
            r_state     <= S_DONE;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: randomized and directed checks of seq_calculator
// (WIDTH=8). The bench compares the DUT against an arithmetic reference model.
module tb_seq_calculator;

  localparam int W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic           i_clk;
  logic           i_reset_n;
  logic           i_start;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic [1:0]     i_selOperator;
  logic           o_busy;
  logic           o_done;
  logic [2*W-1:0] o_result;
  logic           o_divByZero;

  int total;
  int bad;

  int             lat;
  int             busyCnt;
  logic [2*W-1:0] res;
  logic           dbz;

  seq_calculator #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_selOperator (i_selOperator),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_divByZero   (o_divByZero)
  );

  // Free-running clock, 10 time units per period
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference result computed with plain integer arithmetic
  function automatic logic [2*W-1:0] modelResult(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      OP_ADD:  r = ia + ib;
      OP_SUB:  r = ((ia < ib) ? 256 : 0) + ((ia - ib) & 255);
      OP_MUL:  r = ia * ib;
      default: r = (ib == 0) ? 0 : ((ia % ib) * 256 + ia / ib);
    endcase
    return (2*W)'(r);
  endfunction

  function automatic int modelLatency(input logic [1:0] op, input logic [W-1:0] b);
    if (op == OP_MUL || (op == OP_DIV && b != 0)) return W + 1;
    return 1;
  endfunction

  // Issue one operation and wait for o_done. Call this at a negedge with the
  // DUT idle. The task returns at a negedge with the DUT idle again. After
  // acceptance the operand inputs are scrambled every cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_selOperator = op;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = -1;
    busyCnt = 0;
    res = '0;
    dbz = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge i_clk);
      if (o_busy) busyCnt++;
      if (o_done) begin
        lat = c;
        res = o_result;
        dbz = o_divByZero;
      end else begin
        i_a = W'($urandom);
        i_b = W'($urandom);
        i_selOperator = 2'($urandom);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_start = 1'b1;
    i_selOperator = OP_ADD;
    i_a = 8'd3;
    i_b = 8'd4;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl busy=%b done=%b expected 0 0", o_busy, o_done);
    end
    total++;
    if (o_result !== 16'h0000 || o_divByZero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_data result=%h dbz=%b expected 0000 0", o_result, o_divByZero);
    end
    i_reset_n = 1'b1;
    i_start = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_start_ignored busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_add_sub();
    applyStimulus(OP_ADD, 8'd200, 8'd100);
    total++;
    if (lat !== 1 || res !== 16'h012C || dbz !== 1'b0 || busyCnt !== 1) begin
      bad++;
      $display("[TB] FAIL add_200_100 lat=%0d res=%h dbz=%b busy=%0d expected 1 012c 0 1", lat, res, dbz, busyCnt);
    end
    applyStimulus(OP_SUB, 8'd5, 8'd7);
    total++;
    if (lat !== 1 || res !== 16'h01FE || dbz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_5_7 lat=%0d res=%h dbz=%b expected 1 01fe 0", lat, res, dbz);
    end
  endtask

  task automatic test_mul();
    applyStimulus(OP_MUL, 8'd255, 8'd255);
    total++;
    if (lat !== 9 || res !== 16'hFE01 || busyCnt !== 9) begin
      bad++;
      $display("[TB] FAIL mul_max lat=%0d res=%h busy=%0d expected 9 fe01 9", lat, res, busyCnt);
    end
    applyStimulus(OP_MUL, 8'd0, 8'd77);
    total++;
    if (lat !== 9 || res !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL mul_zero lat=%0d res=%h expected 9 0000", lat, res);
    end
  endtask

  task automatic test_div();
    applyStimulus(OP_DIV, 8'd200, 8'd7);
    total++;
    if (lat !== 9 || res !== 16'h041C || dbz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL div_200_7 lat=%0d res=%h dbz=%b expected 9 041c 0", lat, res, dbz);
    end
    applyStimulus(OP_DIV, 8'd3, 8'd9);
    total++;
    if (lat !== 9 || res !== 16'h0300) begin
      bad++;
      $display("[TB] FAIL div_small lat=%0d res=%h expected 9 0300", lat, res);
    end
    applyStimulus(OP_DIV, 8'd50, 8'd0);
    total++;
    if (lat !== 1 || res !== 16'h0000 || dbz !== 1'b1) begin
      bad++;
      $display("[TB] FAIL div_zero lat=%0d res=%h dbz=%b expected 1 0000 1", lat, res, dbz);
    end
    applyStimulus(OP_ADD, 8'd1, 8'd1);
    total++;
    if (res !== 16'h0002 || dbz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dbz_clear res=%h dbz=%b expected 0002 0", res, dbz);
    end
  endtask

  task automatic test_ignore_start();
    int doneCnt;
    logic [2*W-1:0] firstRes;
    doneCnt = 0;
    firstRes = '0;
    i_selOperator = OP_MUL;
    i_a = 8'd13;
    i_b = 8'd11;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        doneCnt++;
        if (doneCnt == 1) firstRes = o_result;
      end
      if (c == 3 || c == 5 || c == 9) begin
        i_start = 1'b1;
        i_selOperator = OP_ADD;
        i_a = 8'd1;
        i_b = 8'd1;
      end else begin
        i_start = 1'b0;
      end
    end
    total++;
    if (doneCnt !== 1 || firstRes !== 16'd143) begin
      bad++;
      $display("[TB] FAIL busy_start_ignored dones=%0d res=%h expected 1 008f", doneCnt, firstRes);
    end
  endtask

  task automatic test_reset_mid();
    int doneCnt;
    logic busyAfter;
    logic [2*W-1:0] resAfter;
    doneCnt = 0;
    busyAfter = 1'b1;
    resAfter = '1;
    applyStimulus(OP_ADD, 8'd10, 8'd20);
    i_selOperator = OP_MUL;
    i_a = 8'd200;
    i_b = 8'd3;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_done) doneCnt++;
      if (c == 4) begin
        busyAfter = o_busy;
        resAfter = o_result;
      end
      i_reset_n = (c == 3) ? 1'b0 : 1'b1;
    end
    total++;
    if (doneCnt !== 0) begin
      bad++;
      $display("[TB] FAIL abort_no_done dones=%0d expected 0", doneCnt);
    end
    total++;
    if (busyAfter !== 1'b0 || resAfter !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL abort_state busy=%b res=%h expected 0 0000", busyAfter, resAfter);
    end
    applyStimulus(OP_ADD, 8'd3, 8'd4);
    total++;
    if (lat !== 1 || res !== 16'h0007) begin
      bad++;
      $display("[TB] FAIL after_abort lat=%0d res=%h expected 1 0007", lat, res);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) a = '1;
      if ($urandom_range(0, 9) == 0) b = '1;
      applyStimulus(op, a, b);
      total++;
      if (res !== modelResult(op, a, b) || lat !== modelLatency(op, b)
          || dbz !== (op == OP_DIV && b == 0)) begin
        bad++;
        $display("[TB] FAIL random_op op=%0d a=%0d b=%0d res=%h lat=%0d dbz=%b expected %h %0d %b",
                 op, a, b, res, lat, dbz, modelResult(op, a, b), modelLatency(op, b), (op == OP_DIV && b == 0));
      end
    end
  endtask

  // Test sequence
  initial begin
    total = 0;
    bad = 0;
    i_reset_n = 1'b0;
    i_start = 1'b0;
    i_a = '0;
    i_b = '0;
    i_selOperator = OP_ADD;
    @(negedge i_clk);
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational calculator.
- Performs add, subtract, multiply and divide on WIDTH-bit unsigned operands.
- Uses a start/done handshake and a registered full-width result.
- Multiply is iterative shift-add; divide is iterative restoring division. This gives FND/BCD display paths a full-precision result plus flags instead of a truncated 4-bit value.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..16.

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_reset_n  input  1  synchronous active-low reset
- i_start  input  1  request pulse; accepted only when o_busy=0
- i_a  input  WIDTH  operand A, unsigned
- i_b  input  WIDTH  operand B, unsigned
- i_selOperator  input  2  00 add, 01 sub, 10 mul, 11 div
- o_busy  output  1  high while an operation is in progress (state != IDLE)
- o_done  output  1  one-cycle pulse; o_result/o_divByZero are valid from this cycle
- o_result  output  2*WIDTH  registered result; format per operator below
- o_divByZero  output  1  high with the result of a divide where i_b==0

Behaviour:
- Reset: i_reset_n sampled low at a rising edge forces:
  - state=IDLE
  - o_busy=0, o_done=0, o_result=0, o_divByZero=0
  - internal counter and registers cleared
  - Reset mid-operation aborts the operation; no o_done is produced.
- Acceptance:
  - i_start=1 in IDLE at edge E latches i_a, i_b, i_selOperator. Later input changes have no effect.
  - i_start while o_busy=1 (including the DONE cycle) is ignored and not queued.
- States: IDLE, CALC, DONE.
  - IDLE -> DONE: add, sub, or div with i_b==0.
  - IDLE -> CALC: mul, or div with i_b!=0.
  - CALC: runs exactly WIDTH iterations (counter WIDTH-1 down to 0). At iteration 0 -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE.
- o_busy: 1 in CALC and DONE, 0 in IDLE.
- o_done: 1 only in DONE.
- o_result and o_divByZero:
  - Update only on the transition into DONE.
  - Hold until the next transition into DONE or reset.
  - o_divByZero is rewritten (set or cleared) with every result.
- Latency from accepting edge E:
  - add/sub and div-by-zero: o_done high in cycle after E (1 cycle).
  - mul/div: o_done high WIDTH+1 cycles after E.
  - Minimum start-to-start spacing: 2 cycles (add/sub), WIDTH+2 cycles (mul/div).
- Result formats, with upper bits zero unless stated:
  - add: bit WIDTH = carry out; bits WIDTH-1:0 = (A+B) mod 2^WIDTH.
  - sub: bit WIDTH = borrow (1 when A<B); bits WIDTH-1:0 = (A-B) mod 2^WIDTH.
  - mul: full 2*WIDTH-bit product A*B; never truncated.
  - div, B!=0: bits WIDTH-1:0 = quotient floor(A/B); bits 2*WIDTH-1:WIDTH = remainder A mod B.
  - div, B==0: o_result=0, o_divByZero=1.
- Multiply algorithm: one partial product per cycle, LSB-first shift-add. Accumulator is 2*WIDTH bits.
- Divide algorithm: one quotient bit per cycle, MSB-first restoring. Partial remainder is WIDTH+1 bits.
- Boundary cases:
  - A=0 or B=0 on mul still takes the full WIDTH iterations.
  - A<B on div gives quotient 0, remainder A.
  - Max operands must not overflow internal registers.
- Simultaneous i_start and reset low: reset wins; the operation is not accepted.

Test Plan:
- WIDTH=8, add A=200 B=100, start at edge E -> o_done at E+1; o_result=0x012C; o_divByZero=0; o_busy high only that cycle.
- WIDTH=8, sub A=5 B=7 -> o_done at E+1; o_result=0x01FE (borrow=1, diff=0xFE).
- WIDTH=8, mul A=255 B=255 -> o_busy high 9 cycles; o_done at E+9; o_result=0xFE01. Changing i_a/i_b mid-operation does not alter the result.
- WIDTH=8, div A=200 B=7 -> o_done at E+9; o_result=0x041C (remainder 4, quotient 28). Then div A=3 B=9 -> o_result=0x0300.
- WIDTH=8, div A=50 B=0 -> o_done at E+1; o_result=0x0000; o_divByZero=1. Next add 1+1 -> o_result=0x0002; o_divByZero=0.
- WIDTH=8, mul start, then i_start pulsed during CALC -> ignored; exactly one o_done. Second mul with i_reset_n low at cycle E+4 -> no o_done; o_busy=0; o_result=0. A start issued afterwards works normally.
